// File: rtl/vtg_pkg.sv
// Shared types and constants for the streaming video timing generator.
package vtg_pkg;

  // Width of the X/Y raster counters and of the o_x/o_y position outputs.
  localparam int CNT_W = 12;

  // Default 640x480 timing.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // IDLE: stopped; RESYNC: raster running, hunting for the frame start beat;
  // RUN: locked, upstream beats are displayed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESYNC = 2'd1,
    ST_RUN    = 2'd2
  } vtg_state_e;

  // Colour bar index (0..7) of a column, eight equal-width bars across the line.
  function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] x,
                                           input int unsigned h_active);
    return 3'((32'(x) * 32'd8) / h_active);
  endfunction

endpackage

// File: rtl/vtg_counter.sv
// Raster position counters (X wraps at HT, Y steps on X wrap and wraps at VT)
// plus active-area, sync-window and frame-end decode of the current position.
module vtg_counter
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_active,
  output logic             o_hs_on,
  output logic             o_vs_on,
  output logic             o_frame_end
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] X_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             w_x_wrap;
  logic             w_y_wrap;

  assign w_x_wrap = (r_x == X_LAST);
  assign w_y_wrap = (r_y == Y_LAST);

  // Advance the raster one pixel per clock; clear holds the position at the origin.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_x_wrap) begin
      r_x <= '0;
      r_y <= w_y_wrap ? '0 : r_y + 1'b1;
    end else begin
      r_x <= r_x + 1'b1;
    end
  end

  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_active    = (r_x < X_ACT) && (r_y < Y_ACT);
  assign o_hs_on     = (r_x >= HS_START) && (r_x < HS_END);
  assign o_vs_on     = (r_y >= VS_START) && (r_y < VS_END);
  assign o_frame_end = w_x_wrap && w_y_wrap;

endmodule

// File: rtl/vtg_stream.sv
// Streaming video timing generator: locks an upstream pixel stream to the
// raster and drives registered video outputs one cycle after each position.
// Optional build macro: VTG_TESTPAT_EN selects colour bars as the fill colour
// (fill is black when undefined).
//
// Handshake: a beat transfers on a rising clock edge where i_valid && o_ready;
// o_ready is combinational from state, position and i_sof and never depends
// on i_valid. While hunting (RESYNC) non-sof beats are drained and the sof
// beat is held; while locked (RUN) a beat is taken at every active position.
module vtg_stream
  import vtg_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 8
) (
  input  logic             i_pixclk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic             i_sof,
  input  logic [CW-1:0]    i_red,
  input  logic [CW-1:0]    i_grn,
  input  logic [CW-1:0]    i_blu,
  output logic             o_ready,
  output logic [CW-1:0]    o_red,
  output logic [CW-1:0]    o_grn,
  output logic [CW-1:0]    o_blu,
  output logic             o_de,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_newline,
  output logic             o_newframe,
  output logic             o_underflow,
  output logic             o_sync_err,
  output logic [1:0]       o_dbg_state
);

  localparam logic [CNT_W-1:0] X_LAST_ACT = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST_ACT = CNT_W'(V_ACTIVE - 1);

  vtg_state_e       r_state;
  vtg_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;
  logic             w_active;
  logic             w_hs_on;
  logic             w_vs_on;
  logic             w_frame_end;
  logic             w_cnt_clear;
  logic             w_origin;
  logic             w_underflow;
  logic             w_sync_err;
  logic             w_use_input;
  logic [CW-1:0]    w_fill_r;
  logic [CW-1:0]    w_fill_g;
  logic [CW-1:0]    w_fill_b;

  logic             r_de;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_newline;
  logic             r_newframe;
  logic             r_underflow;
  logic             r_sync_err;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic [CW-1:0]    r_red;
  logic [CW-1:0]    r_grn;
  logic [CW-1:0]    r_blu;

  // Counters sit at the origin while idle or about to go idle, so the first
  // RESYNC cycle always starts at pixel (0,0).
  assign w_cnt_clear = !i_enable || (r_state == ST_IDLE);

  vtg_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_counter (
    .i_clk       (i_pixclk),
    .i_reset     (i_reset),
    .i_clear     (w_cnt_clear),
    .o_x         (w_x),
    .o_y         (w_y),
    .o_active    (w_active),
    .o_hs_on     (w_hs_on),
    .o_vs_on     (w_vs_on),
    .o_frame_end (w_frame_end)
  );

  assign w_origin = (w_x == '0) && (w_y == '0);

`ifdef VTG_TESTPAT_EN
  logic [2:0] w_bar;

  // Eight vertical bars: bar 0 white down to bar 7 black, each channel fully on or off.
  always_comb begin
    w_bar    = bar_index(w_x, H_ACTIVE);
    w_fill_r = {CW{~w_bar[2]}};
    w_fill_g = {CW{~w_bar[1]}};
    w_fill_b = {CW{~w_bar[0]}};
  end
`else
  assign w_fill_r = '0;
  assign w_fill_g = '0;
  assign w_fill_b = '0;
`endif

  // State register.
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, ready and error detection; a low i_enable always wins.
  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    w_underflow = 1'b0;
    w_sync_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable) w_state_nxt = ST_RESYNC;
      end
      ST_RESYNC: begin
        o_ready = ~i_sof;
        if (w_frame_end && i_valid && i_sof) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        o_ready = w_active;
        if (w_active && !i_valid) begin
          w_underflow = 1'b1;
          w_state_nxt = ST_RESYNC;
        end else if (w_active && (i_sof != w_origin)) begin
          w_sync_err  = 1'b1;
          w_state_nxt = ST_RESYNC;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!i_enable) w_state_nxt = ST_IDLE;
  end

  assign w_use_input = (r_state == ST_RUN) && w_active && i_valid;

  // Registered video outputs for the current position, plus sticky flags.
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      r_de        <= 1'b0;
      r_hsync     <= ~HS_POL;
      r_vsync     <= ~VS_POL;
      r_newline   <= 1'b0;
      r_newframe  <= 1'b0;
      r_underflow <= 1'b0;
      r_sync_err  <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_red       <= '0;
      r_grn       <= '0;
      r_blu       <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_de       <= 1'b0;
        r_hsync    <= ~HS_POL;
        r_vsync    <= ~VS_POL;
        r_newline  <= 1'b0;
        r_newframe <= 1'b0;
        r_x        <= '0;
        r_y        <= '0;
        r_red      <= '0;
        r_grn      <= '0;
        r_blu      <= '0;
      end else begin
        r_de       <= w_active;
        r_hsync    <= w_hs_on ? HS_POL : ~HS_POL;
        r_vsync    <= w_vs_on ? VS_POL : ~VS_POL;
        r_newline  <= w_active && (w_x == X_LAST_ACT);
        r_newframe <= w_active && (w_x == X_LAST_ACT) && (w_y == Y_LAST_ACT);
        r_x        <= w_active ? w_x : '0;
        r_y        <= w_active ? w_y : '0;
        if (w_use_input) begin
          r_red <= i_red;
          r_grn <= i_grn;
          r_blu <= i_blu;
        end else if (w_active) begin
          r_red <= w_fill_r;
          r_grn <= w_fill_g;
          r_blu <= w_fill_b;
        end else begin
          r_red <= '0;
          r_grn <= '0;
          r_blu <= '0;
        end
      end
      if (w_underflow) r_underflow <= 1'b1;
      if (w_sync_err)  r_sync_err  <= 1'b1;
    end
  end

  assign o_de        = r_de;
  assign o_hsync     = r_hsync;
  assign o_vsync     = r_vsync;
  assign o_newline   = r_newline;
  assign o_newframe  = r_newframe;
  assign o_underflow = r_underflow;
  assign o_sync_err  = r_sync_err;
  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_red       = r_red;
  assign o_grn       = r_grn;
  assign o_blu       = r_blu;
  assign o_dbg_state = r_state;

endmodule

// File: doc/vtg_stream.md
VTG_STREAM -- requirements
Module: vtg_stream

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 640 active pixels/line; H_FP 16 h front porch; H_SYNC 96 h sync width; H_BP 48 h back porch; V_ACTIVE 480 active lines; V_FP 10; V_SYNC 2; V_BP 33; HS_POL 0 hsync active level; VS_POL 0 vsync active level; CW 8 colour width.
REQ-002 One clock; reset is synchronous and active-high. Ports: i_pixclk in 1 pixel clock; i_reset in 1 sync active-high reset.
REQ-003 i_enable in 1 run request; i_valid in 1 upstream beat valid; i_sof in 1 beat is pixel (0,0); i_red/i_grn/i_blu in CW each pixel colour.
REQ-004 o_ready out 1 beat accepted when i_valid&o_ready; o_red/o_grn/o_blu out CW each; o_de out 1 display enable; o_hsync/o_vsync out 1 each; o_x/o_y out 12 each, pixel position.
REQ-005 o_newline out 1 last active pixel of line; o_newframe out 1 last active pixel of frame; o_underflow out 1 sticky; o_sync_err out 1 sticky.

Function
REQ-006 HT=H_ACTIVE+H_FP+H_SYNC+H_BP, VT likewise; X counts 0..HT-1 and wraps; Y increments on X wrap and counts 0..VT-1, wrapping to 0.
REQ-007 Active position: X<H_ACTIVE and Y<V_ACTIVE. hsync asserted for X in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync for Y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); output level = POL when asserted, ~POL otherwise.
REQ-008 All outputs except o_ready are registered; each output cycle reflects the counter position of the previous cycle (latency 1).
REQ-009 States: IDLE, RESYNC, RUN. IDLE: counters held at 0, o_ready=0, o_de=0, colours 0, syncs inactive.
REQ-010 IDLE->RESYNC when i_enable=1; any state->IDLE when i_enable=0 (next cycle).
REQ-011 RESYNC: counters run; o_ready = ~i_sof (combinational), beats without sof discarded; beat with sof held (not accepted); at X=HT-1,Y=VT-1 with i_valid&i_sof -> RUN.
REQ-012 RUN: o_ready=1 exactly at active positions, else 0; accepted beat appears on o_red/grn/blu with o_de=1 next cycle.
REQ-013 Underflow: RUN, active position, i_valid=0 -> that pixel output as fill colour, o_underflow set, state -> RESYNC.
REQ-014 Sync error: in RUN, accepted beat with i_sof≠(X==0&&Y==0) -> pixel still output, o_sync_err set, state -> RESYNC.
REQ-015 Blank positions and RESYNC active positions: o_de=0 in blanking, o_de=1 with fill colour in RESYNC active area.
REQ-016 o_newline=1 with the output of pixel X=H_ACTIVE-1 (any active line); o_newframe=1 additionally requires Y=V_ACTIVE-1; both single-cycle, independent of state except IDLE.
REQ-017 o_x/o_y carry the output pixel's counters, 0 outside active area.
REQ-018 Sticky flags clear only on i_reset.

Reset
REQ-019 On i_reset: state IDLE, X=Y=0, o_de/o_newline/o_newframe/o_underflow/o_sync_err=0, colours 0, o_x/o_y 0, o_hsync=~HS_POL, o_vsync=~VS_POL; reset dominates i_enable.
REQ-020 Reset mid-frame abandons the frame; the first post-reset output cycle is IDLE-blank.

Configuration
REQ-021 VTG_TESTPAT_EN defined: fill colour = 8 vertical colour bars, bar index = X*8/H_ACTIVE, colour bits {R,G,B}=~index[2:0] fully on/off (bar 0 white, bar 7 black).
REQ-022 VTG_TESTPAT_EN undefined: fill colour = 0; no bar logic synthesised.

Structure
REQ-023 Package vtg_pkg: state enum, default 640x480 timing constants, counter width 12.
REQ-024 Sub-module vtg_counter: X/Y counters, active and sync decode; vtg_stream holds the FSM, data path and flags.

Verification (params H 8/2/2/2, V 4/1/1/1, HT=14, VT=7, CW=8, pols 1)
REQ-025 Reset then i_enable=1, source sends sof-aligned frame, pixel value = X+8Y -> from second frame o_de pixels match, no flags, o_newframe at (7,3).
REQ-026 i_valid dropped at (3,1) in RUN -> o_underflow=1, fill at (3,1), RESYNC, RUN regained at next frame start after sof beat.
REQ-027 Beat with i_sof=1 accepted at (5,2) -> o_sync_err=1, RESYNC, non-sof beats drained.
REQ-028 Sync check over a frame -> o_hsync=1 only at X 10..11, o_vsync=1 only at Y=5, each one cycle after counter position.
REQ-029 i_reset during RUN at (4,2) -> next cycle all outputs at reset values, flags cleared.
REQ-030 With VTG_TESTPAT_EN, source idle -> RESYNC active pixels X=0 white FFFFFF, X=7 black 000000; without macro all 0.
